// File: rtl/mips_writeback_queue.sv
// Writeback queue for the MIPS register file write port: accepts ALU and load
// writebacks, drains one per cycle in order, and bypasses pending data to reads.
module mips_writeback_queue #(
    parameter int AWL   = 5,
    parameter int DWL   = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [AWL-1:0]             ld_addr,
    input  logic [DWL-1:0]             ld_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AWL-1:0]             alu_addr,
    input  logic [DWL-1:0]             alu_data,
    input  logic                       hold,
    output logic                       wen,
    output logic [AWL-1:0]             WA,
    output logic [DWL-1:0]             WD,
    input  logic [AWL-1:0]             RA1,
    input  logic [AWL-1:0]             RA2,
    output logic                       byp1_hit,
    output logic [DWL-1:0]             byp1_data,
    output logic                       byp2_hit,
    output logic [DWL-1:0]             byp2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a source transfers on a rising edge where valid && ready.
    // ready never depends on the same source's valid, only on registered
    // occupancy (and, for the ALU, on whether the load unit is also asking).

    logic [AWL-1:0] addr_q [DEPTH];
    logic [AWL-1:0] addr_d [DEPTH];
    logic [DWL-1:0] data_q [DEPTH];
    logic [DWL-1:0] data_d [DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, alu_slot;
    logic [CW-1:0]  count_q, count_d, free;
    logic           ld_store, alu_store, pop;

    always_comb begin
        free      = CW'(DEPTH) - count_q;
        ld_ready  = !rst && (free >= CW'(1));
        alu_ready = !rst && ((free >= CW'(2)) || ((free >= CW'(1)) && !ld_valid));
        // Writes to $zero handshake normally but are dropped here.
        ld_store  = ld_valid && ld_ready && (ld_addr != '0);
        alu_store = alu_valid && alu_ready && (alu_addr != '0);

        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        count = count_q;
        wen   = !empty && !hold && !rst;
        pop   = wen;
        WA    = addr_q[head_q];
        WD    = data_q[head_q];

        addr_d   = addr_q;
        data_d   = data_q;
        alu_slot = tail_q + PW'(ld_store);
        if (ld_store) begin
            addr_d[tail_q] = ld_addr;
            data_d[tail_q] = ld_data;
        end
        if (alu_store) begin
            addr_d[alu_slot] = alu_addr;
            data_d[alu_slot] = alu_data;
        end
        tail_d  = tail_q + PW'(ld_store) + PW'(alu_store);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(ld_store) + CW'(alu_store) - CW'(pop);
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        byp1_hit  = 1'b0;
        byp1_data = '0;
        byp2_hit  = 1'b0;
        byp2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((RA1 != '0) && (addr_q[head_q + PW'(i)] == RA1)) begin
                    byp1_hit  = 1'b1;
                    byp1_data = data_q[head_q + PW'(i)];
                end
                if ((RA2 != '0) && (addr_q[head_q + PW'(i)] == RA2)) begin
                    byp2_hit  = 1'b1;
                    byp2_data = data_q[head_q + PW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: doc/mips_writeback_queue.md
Name: mips_writeback_queue

Overview:
- Write-side controller for the MIPS register file's single synchronous write port.
- Accepts register writebacks from two pipeline sources, the ALU and the load unit, each over a valid/ready handshake.
- Buffers them in a small in-order queue and drains one entry per cycle onto the register file's wen/WA/WD.
- Gives the read ports a youngest-match bypass, so reads of registers with pending writes return the queued data.

Parameters:
AWL, 5, register address width
DWL, 32, register data width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ld_valid  in  1  load-unit writeback request
ld_ready  out  1  load-unit request accepted this cycle when ld_valid=1
ld_addr  in  AWL  load destination register
ld_data  in  DWL  load result
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle when alu_valid=1
alu_addr  in  AWL  ALU destination register
alu_data  in  DWL  ALU result
hold  in  1  1 = suppress draining this cycle
wen  out  1  register file write enable
WA  out  AWL  register file write address
WD  out  DWL  register file write data
RA1  in  AWL  register file read address 1 (snooped)
RA2  in  AWL  register file read address 2 (snooped)
byp1_hit  out  1  RA1 has a pending queued write
byp1_data  out  DWL  youngest pending data for RA1
byp2_hit  out  1  RA2 has a pending queued write
byp2_data  out  DWL  youngest pending data for RA2
count  out  clog2(DEPTH)+1  occupied entries
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high.
- Reset state: pointers cleared, count=0, empty=1, full=0, wen=0, byp*_hit=0.
  - While rst=1, ld_ready=alu_ready=0.
  - Reset mid-operation discards all queued entries; no further wen for them.
- Free space: free = DEPTH - count, computed from registered count only. Space freed by a drain is visible next cycle.
- Readiness:
  - ld_ready = (free>=1).
  - alu_ready = (free>=2) || (free>=1 && !ld_valid).
  - The load unit wins when only one slot is free.
- Acceptance: a handshake completes when valid&&ready at a rising edge.
- Enqueue order: when both sources are accepted in the same cycle, the load entry is enqueued first (older), then the ALU entry.
- Register 0: a request with addr==0 is accepted (ready as above) but never stored; count is unaffected. This is MIPS $zero semantics.
- Drain outputs: combinational from the head entry. wen = !empty && !hold; WA/WD = head addr/data.
  - When wen=1, the head is popped at the rising edge.
  - WA/WD are don't-care when wen=0.
- Latency: an entry accepted at edge N is driven on wen/WA/WD in cycle N+1 at the earliest. The register file commits it at edge N+1.
- Simultaneous events: in one cycle, up to two enqueues and one pop may occur. count_next = count + enq - pop.
  - Full queue with a pop: readies are still 0 that cycle, so no pass-through.
- Pointer wrap: pointers wrap modulo DEPTH; full and empty derive from count.
- Bypass:
  - bypN_hit = (RAN!=0) && some occupied entry has addr==RAN.
  - bypN_data = data of the youngest such entry.
  - The head entry being drained this cycle still counts.
  - Requests arriving this cycle do not count.
  - Purely combinational from RAN and the stored state.
- Same address queued twice: both writes drain in order, so the register file ends with the younger value.

Test Plan:
- Single write: reset, then ld_valid=1, ld_addr=5, ld_data=0xDEADBEEF for 1 cycle -> next cycle wen=1, WA=5, WD=0xDEADBEEF, count=1; cycle after, wen=0, empty=1.
- Dual accept with ordering: both valid with ld (3,0x11) and alu (3,0x22), count=0, hold=1 -> count=2; RA1=3 gives byp1_hit=1, byp1_data=0x22. Release hold -> WA=3/WD=0x11, then WA=3/WD=0x22.
- Fill and arbitration: hold=1 until count=3; both valid -> ld_ready=1, alu_ready=0, count becomes 4, full=1; both readies 0 the next cycle.
- Register zero: alu_valid with alu_addr=0, data=0xFFFF -> alu_ready=1, count stays 0, no wen; RA2=0 gives byp2_hit=0.
- Reset mid-operation: with count=3 and hold=1, assert rst for 1 cycle -> count=0, empty=1, wen=0, byp hits 0; no queued entry ever appears on WA/WD.
- Wrap and throughput: hold=0; single ALU write per cycle to addresses 1..10 -> wen asserted on 10 consecutive cycles with WA 1..10 in order, count never exceeds 1.
